// File: rtl/synapse_pkg.sv
// rtl/synapse_pkg.sv - shared state encoding and default geometry for the synapse access controller
package synapse_pkg;

  localparam int SYN_N_WORDS    = 32;
  localparam int SYN_ADDR_W     = 7;
  localparam int SYN_RD_LAT     = 2;
  localparam int SYN_ADDR_OUT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } syn_state_t;

  // The spare encoding is folded into IDLE so a corrupted state register recovers.
  function automatic syn_state_t decode_state(input logic [1:0] enc);
    case (enc)
      2'd1:    return ST_LOAD;
      2'd2:    return ST_RUN;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/syn_rr_arb.sv
// rtl/syn_rr_arb.sv - two-requester read/write arbiter; SYN_CTRL_RR_EN selects round-robin, else read priority
module syn_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_rd,
  input  logic req_wr,
  output logic gnt_rd,
  output logic gnt_wr
);

  logic ptr_wr;
  logic ptr_nxt;

  always_comb begin
    gnt_rd = 1'b0;
    gnt_wr = 1'b0;
    if (en) begin
      if (req_rd && (!req_wr || !ptr_wr)) begin
        gnt_rd = 1'b1;
      end else if (req_wr) begin
        gnt_wr = 1'b1;
      end
    end
  end

`ifdef SYN_CTRL_RR_EN
  // Only a contested grant moves the pointer; lone requests leave fairness state alone.
  assign ptr_nxt = (en && req_rd && req_wr) ? ~ptr_wr : ptr_wr;
`else
  assign ptr_nxt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_wr <= 1'b0;
    end else begin
      ptr_wr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/synapse_access_ctrl.sv
// rtl/synapse_access_ctrl.sv - weight-table loader and read/write access controller (SYN_CTRL_RR_EN: round-robin arbitration)
module synapse_access_ctrl
  import synapse_pkg::*;
#(
  parameter int N_WORDS = SYN_N_WORDS,
  parameter int ADDR_W  = SYN_ADDR_W,
  parameter int RD_LAT  = SYN_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  output logic              load_done,
  output logic [1:0]        state_o,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_vld,
  output logic [7:0]        rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_gnt,
  output logic              syn_rst_n,
  output logic [15:0]       syn_addr,
  output logic [31:0]       syn_wdata,
  output logic              syn_wen,
  output logic              syn_ren,
  input  logic [7:0]        syn_weight
);

  localparam int CNT_W = $clog2(N_WORDS + 1);

  logic [1:0]        state_q;
  syn_state_t        cur_state;
  syn_state_t        state_nxt;
  logic [CNT_W-1:0]  word_cnt;
  logic [RD_LAT-1:0] vld_sr;
  logic              ld_acc;
  logic              last_word;
  logic              gnt_rd;
  logic              gnt_wr;

  assign cur_state = decode_state(state_q);
  assign state_o   = state_q;
  assign ld_acc    = (cur_state == ST_LOAD) && ld_valid;
  assign last_word = ld_acc && (word_cnt == CNT_W'(N_WORDS - 1));

  syn_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (cur_state == ST_RUN),
    .req_rd (rd_req),
    .req_wr (wr_req),
    .gnt_rd (gnt_rd),
    .gnt_wr (gnt_wr)
  );

  assign rd_gnt = gnt_rd;
  assign wr_gnt = gnt_wr;

  always_comb begin
    state_nxt = cur_state;
    case (cur_state)
      ST_IDLE: if (load_start) state_nxt = ST_LOAD;
      ST_LOAD: if (last_word)  state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
    if (kill) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      word_cnt  <= '0;
      load_done <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      load_done <= last_word && !kill;
      if (kill || cur_state != ST_LOAD) begin
        word_cnt <= '0;
      end else if (ld_acc && word_cnt != CNT_W'(N_WORDS)) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  // Read-valid pipeline mirrors the synapse array latency; kill drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= RD_LAT'({vld_sr, gnt_rd});
    end
  end

  assign rd_vld  = vld_sr[RD_LAT-1];
  assign rd_data = rd_vld ? syn_weight : 8'h00;

  always_comb begin
    ld_ready  = 1'b0;
    syn_rst_n = 1'b1;
    syn_wen   = 1'b0;
    syn_ren   = 1'b0;
    syn_addr  = '0;
    syn_wdata = '0;
    case (cur_state)
      ST_LOAD: begin
        ld_ready  = 1'b1;
        syn_rst_n = 1'b0;
        syn_wen   = ld_valid;
        syn_wdata = ld_data;
        syn_addr  = SYN_ADDR_OUT_W'(word_cnt) << 2;
      end
      ST_RUN: begin
        syn_ren = gnt_rd;
        syn_wen = gnt_wr;
        if (gnt_rd) begin
          syn_addr = SYN_ADDR_OUT_W'(rd_addr);
        end else if (gnt_wr) begin
          syn_addr  = SYN_ADDR_OUT_W'(wr_addr);
          syn_wdata = {24'b0, wr_data};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/synapse_access_ctrl.md
SYNAPSE_ACCESS_CTRL -- requirements
Module: synapse_access_ctrl

Interface
REQ-001 The block SHALL have parameter N_WORDS, default 32, weight-table depth in 32-bit words.
REQ-002 The block SHALL have parameter ADDR_W, default 7, byte-address width (N_WORDS*4 bytes).
REQ-003 The block SHALL have parameter RD_LAT, default 2, synapse read latency in cycles from syn_ren to valid syn_weight.
REQ-004 Ports SHALL be:
 clk  in  1  sole clock, rising edge
 rst  in  1  reset, synchronous, active-high
 kill  in  1  abort current load/run, return to IDLE
 load_start  in  1  one-cycle pulse, begin table load
 ld_valid  in  1  load word valid
 ld_data  in  32  load word
 ld_ready  out  1  load word accepted when ld_valid&ld_ready
 load_done  out  1  one-cycle pulse after last word
 state_o  out  2  current state encoding
 rd_req  in  1  spike-lookup request
 rd_addr  in  ADDR_W  byte address of weight
 rd_gnt  out  1  read granted this cycle
 rd_vld  out  1  rd_data valid
 rd_data  out  8  returned weight
 wr_req  in  1  STDP update request
 wr_addr  in  ADDR_W  byte address
 wr_data  in  8  new weight
 wr_gnt  out  1  write granted this cycle
 syn_rst_n  out  1  synapse init enable, low during LOAD
 syn_addr  out  16  synapse byte address, zero-extended
 syn_wdata  out  32  synapse write data
 syn_wen  out  1  synapse write enable
 syn_ren  out  1  synapse read enable
 syn_weight  in  8  synapse read data

Function
REQ-005 States SHALL be IDLE=0, LOAD=1, RUN=2; encoding 3 unused, decoded as IDLE.
REQ-006 IDLE->LOAD on load_start; LOAD->RUN the cycle after the N_WORDS-th accepted word; any state->IDLE on kill (kill dominates load_start).
REQ-007 In LOAD: syn_rst_n=0, ld_ready=1, syn_wen=ld_valid, syn_wdata=ld_data, word counter increments per accepted word, no wrap.
REQ-008 load_done SHALL pulse for one cycle on the LOAD->RUN transition.
REQ-009 In RUN: syn_rst_n=1; at most one of rd_gnt/wr_gnt per cycle; syn_ren=rd_gnt, syn_wen=wr_gnt, never both.
REQ-010 Grant SHALL be combinational from requests and arbitration state; requester holds req/addr/data until its gnt.
REQ-011 syn_addr SHALL equal granted address; syn_wdata SHALL be {24'b0, wr_data} on write grant.
REQ-012 rd_vld SHALL assert exactly RD_LAT cycles after rd_gnt with rd_data=syn_weight in that cycle; back-to-back reads SHALL pipeline (shift register of valids).
REQ-013 A write granted while a read to the same word is in flight SHALL NOT alter that read's result ordering; no forwarding.
REQ-014 Requests outside RUN SHALL be ignored (no gnt); kill SHALL flush in-flight rd_vld pipeline.
REQ-015 Addresses >= N_WORDS*4 SHALL be granted but masked to ADDR_W bits.

Reset
REQ-016 On rst: state IDLE, counter 0, arbitration pointer to read, rd_vld pipeline cleared, rd_data=0, all outputs 0 except syn_rst_n=1.

Configuration
REQ-017 With SYN_CTRL_RR_EN defined, simultaneous rd_req/wr_req SHALL alternate grants (round-robin, pointer flips after each contested grant); without it, reads SHALL have fixed priority over writes.

Structure
REQ-018 State encoding, N_WORDS/ADDR_W defaults and RD_LAT SHALL reside in package synapse_pkg.
REQ-019 Arbitration SHALL be a sub-module syn_rr_arb (2-requester, macro-controlled policy).

Verification
REQ-020 load_start, 32 words 0x00..0x1F streamed -> 32 syn_wen pulses, syn_rst_n low throughout, load_done at word 32+1 cycle, state_o=2.
REQ-021 RUN, rd_req addr 5 -> rd_gnt same cycle, rd_vld 2 cycles later with rd_data=syn_weight.
REQ-022 Simultaneous rd/wr for 4 cycles: with SYN_CTRL_RR_EN grants R,W,R,W; without, R,R,R,R.
REQ-023 kill mid-LOAD after 10 words -> IDLE next cycle, ld_ready=0, no load_done.
REQ-024 rst asserted with 2 reads in flight -> no rd_vld afterward, all outputs at reset values.
